// File: rtl/bcd_serial_addsub.sv
// Serial packed-BCD adder/subtractor: one digit per clock, LSD first, start/busy/done handshake.
// Latency DIGITS+1 cycles from accepted start to done; start is ignored while busy.
module bcd_serial_addsub #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                sub,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] sum,
   output logic                cout,
   output logic                invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            sub_q;
   logic            carry;
   logic [IW-1:0]   idx;

   logic [3:0]      a_d;
   logic [3:0]      b_d;
   logic [3:0]      bd;
   logic [4:0]      t;
   logic [4:0]      t6;
   logic [3:0]      rd;
   logic            nc;
   logic            bad;
   logic            last;

   // Single-digit add-and-correct stage; subtraction uses the nine's complement of b.
   always_comb begin
      a_d  = a_q[4*idx +: 4];
      b_d  = b_q[4*idx +: 4];
      bd   = sub_q ? (4'd9 - b_d) : b_d;
      t    = {1'b0, a_d} + {1'b0, bd} + {4'b0000, carry};
      t6   = t + 5'd6;
      rd   = t[3:0];
      nc   = 1'b0;
      if (t > 5'd9) begin
         rd = t6[3:0];
         nc = 1'b1;
      end
      bad  = (a_d > 4'd9) || (b_d > 4'd9);
      last = (idx == IW'(DIGITS - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry   <= 1'b0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  sub_q   <= sub;
                  carry   <= sub ? ~cin : cin;
                  idx     <= '0;
                  sum     <= '0;
                  invalid <= 1'b0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state   <= IDLE;
               end
            end
            RUN: begin
               sum[4*idx +: 4] <= rd;
               invalid         <= invalid | bad;
               carry           <= nc;
               if (last) begin
                  idx   <= '0;
                  cout  <= sub_q ? ~nc : nc;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx   <= idx + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub (DIGITS=4): directed cases plus random ops against a decimal-arithmetic model.
module tb_bcd_serial_addsub;

   localparam int D = 4;
   localparam int N = 10000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sub;
   logic [4*D-1:0] a;
   logic [4*D-1:0] b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [4*D-1:0] sum;
   logic          cout;
   logic          invalid;

   int checks   = 0;
   int failures = 0;

   bcd_serial_addsub #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [4*D-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [4*D-1:0] int2bcd(input int v);
      logic [4*D-1:0] r = '0;
      int x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Decimal reference: plain integer arithmetic modulo 10^D.
   task automatic model(input logic s, input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                        input logic c, output logic [4*D-1:0] es, output logic ec, output logic ei);
      int r;
      ei = 1'b0;
      for (int i = 0; i < D; i++)
         if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) ei = 1'b1;
      if (s) r = bcd2int(av) - bcd2int(bv) - int'(c);
      else   r = bcd2int(av) + bcd2int(bv) + int'(c);
      ec = 1'b0;
      if (r < 0) begin
         r  = r + N;
         ec = 1'b1;
      end else if (r >= N) begin
         r  = r - N;
         ec = 1'b1;
      end
      es = int2bcd(r);
   endtask

   task automatic start_op(input logic s, input logic [4*D-1:0] av, input logic [4*D-1:0] bv, input logic c);
      @(negedge clk);
      start = 1'b1; sub = s; a = av; b = bv; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("no_done_after_start", done, 1'b0);
   endtask

   task automatic wait_done(input int c0, output int cnt);
      cnt = c0;
      while (!done && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic run_op(input string tag, input logic s, input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                         input logic c, input logic [4*D-1:0] es, input logic ec, input logic ei,
                         input bit chk_val);
      int cnt;
      start_op(s, av, bv, c);
      wait_done(1, cnt);
      chk({tag, "_latency"}, 64'(cnt), 64'(D + 1));
      chk({tag, "_busy_low_at_done"}, busy, 1'b0);
      if (chk_val) begin
         chk({tag, "_sum"}, sum, es);
         chk({tag, "_cout"}, cout, ec);
      end
      chk({tag, "_invalid"}, invalid, ei);
   endtask

   task automatic model_op(input string tag, input logic s, input logic [4*D-1:0] av,
                           input logic [4*D-1:0] bv, input logic c);
      logic [4*D-1:0] es;
      logic ec, ei;
      model(s, av, bv, c, es, ec, ei);
      run_op(tag, s, av, bv, c, es, ec, ei, !ei);
   endtask

   task automatic idle_hold(input logic [4*D-1:0] es);
      @(posedge clk); #1;
      chk("done_single_pulse", done, 1'b0);
      chk("sum_held", sum, es);
   endtask

   initial begin
      logic [4*D-1:0] ra, rb;
      int cnt, ndone;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, 16'h0000);
      chk("rst_cout", cout, 1'b0);
      chk("rst_invalid", invalid, 1'b0);
      @(negedge clk); rst = 1'b0;

      // Directed arithmetic cases.
      run_op("add1", 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
      idle_hold(16'h6912);
      run_op("add1c", 1'b0, 16'h1234, 16'h5678, 1'b1, 16'h6913, 1'b0, 1'b0, 1'b1);
      idle_hold(16'h6913);
      run_op("wrap", 1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      idle_hold(16'h0000);
      for (int n = 0; n < 10; n++)
         model_op("sweep", 1'b0, 16'(n), 16'(n), 1'b1);
      run_op("sub1", 1'b1, 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0, 1'b1);
      run_op("sub2", 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);
      run_op("sub3", 1'b1, 16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
      idle_hold(16'h0000);

      // Non-BCD digit: digit1 = (10+6) mod 16 with carry into digit2.
      run_op("inv", 1'b0, 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b1);
      run_op("inv_clear", 1'b0, 16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1);
      idle_hold(16'h0009);

      // start pulses while busy are ignored.
      start_op(1'b0, 16'h2222, 16'h3333, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(3, cnt);
      chk("ignore_latency", 64'(cnt), 64'(D + 1));
      chk("ignore_sum", sum, 16'h5555);
      chk("ignore_cout", cout, 1'b0);
      idle_hold(16'h5555);

      // Back-to-back: start during the DONE cycle.
      run_op("b2b_first", 1'b0, 16'h0450, 16'h0550, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
      run_op("b2b_second", 1'b1, 16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b1);
      idle_hold(16'h0999);

      // Reset mid-operation aborts without a done pulse.
      run_op("pre_rst", 1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      start_op(1'b0, 16'h1234, 16'h1111, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_sum", sum, 16'h0000);
      chk("midrst_cout", cout, 1'b0);
      chk("midrst_done", done, 1'b0);
      @(negedge clk); rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      run_op("post_rst", 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

      // Random valid-BCD operations.
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < D; i++) begin
            ra[4*i +: 4] = 4'($urandom_range(0, 9));
            rb[4*i +: 4] = 4'($urandom_range(0, 9));
         end
         model_op("rand", 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end

      // Random raw nibbles: invalid flag must track any digit > 9.
      for (int k = 0; k < 10; k++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         model_op("rand_raw", 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
